// File: rtl/mem_stage_wb.sv
// mem_stage_wb: MIPS MEM stage with multi-cycle data memory, branch resolve and MEM/WB register
module mem_stage_wb #(
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_read_rb_2,
    input  logic [31:0] i_branch_address,
    input  logic [4:0]  i_inst_mux_br_write_address,
    input  logic        i_zf,
    input  logic        i_branch,
    input  logic        i_memWrite,
    input  logic        i_memRead,
    input  logic        i_regWrite,
    input  logic        i_memToReg,
    output logic        o_pc_src,
    output logic [31:0] o_branch_target,
    output logic        o_stall,
    output logic [31:0] o_read_data,
    output logic [31:0] o_alu_result,
    output logic [4:0]  o_write_address,
    output logic        o_regWrite,
    output logic        o_memToReg,
    output logic        o_misaligned
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [31:0] mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic req, access, misal, stall, done;
    logic [31:0] read_data_q, read_data_d, alu_result_q, alu_result_d;
    logic [4:0] write_address_q, write_address_d;
    logic regwrite_q, regwrite_d, memtoreg_q, memtoreg_d, misaligned_q, misaligned_d;
    always_comb begin
        idx    = i_alu_result[ADDR_W+1:2];
        req    = i_memRead | i_memWrite;
        access = req & (i_alu_result[1:0] == 2'b00);
        misal  = req & (i_alu_result[1:0] != 2'b00);
        stall  = (state_q == BUSY) ? (cnt_q != 4'd0) : (access && MEM_LATENCY > 1);
        // inputs are held while stalled, so a non-stalled access cycle is the completion edge
        done   = access & ~stall;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == BUSY) begin
            state_d = (cnt_q == 4'd0) ? IDLE : BUSY;
            cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        end else if (stall) begin
            state_d = BUSY;
            cnt_d   = 4'(MEM_LATENCY - 2);
        end
        read_data_d     = (done & i_memRead) ? (i_memWrite ? 32'd0 : mem_q[idx]) : read_data_q;
        alu_result_d    = i_alu_result;
        write_address_d = i_inst_mux_br_write_address;
        regwrite_d      = i_regWrite & ~stall & ~misal;
        memtoreg_d      = i_memToReg & ~stall;
        misaligned_d    = misal;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= 4'd0;
            read_data_q     <= 32'd0;
            alu_result_q    <= 32'd0;
            write_address_q <= 5'd0;
            regwrite_q      <= 1'b0;
            memtoreg_q      <= 1'b0;
            misaligned_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            read_data_q     <= read_data_d;
            alu_result_q    <= alu_result_d;
            write_address_q <= write_address_d;
            regwrite_q      <= regwrite_d;
            memtoreg_q      <= memtoreg_d;
            misaligned_q    <= misaligned_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && done && i_memWrite) mem_q[idx] <= i_read_rb_2;
    end
    assign o_pc_src        = i_branch & i_zf;
    assign o_branch_target = i_branch_address;
    assign o_stall         = stall;
    assign o_read_data     = read_data_q;
    assign o_alu_result    = alu_result_q;
    assign o_write_address = write_address_q;
    assign o_regWrite      = regwrite_q;
    assign o_memToReg      = memtoreg_q;
    assign o_misaligned    = misaligned_q;
endmodule

// File: tb/tb_mem_stage_wb.sv
// tb_mem_stage_wb: three DUTs (latency 1,2,3) checked against a word-array reference model
module tb_mem_stage_wb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] alu_r [3], rb2 [3], baddr [3];
    logic [4:0]  wa [3];
    logic        zf [3], br [3], mw [3], mr [3], rw [3], m2r [3];
    logic        pc_src [3], stall [3], o_rw [3], o_m2r [3], o_mis [3];
    logic [31:0] tgt [3], o_rd [3], o_alu [3];
    logic [4:0]  o_wa [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stage_wb #(.ADDR_W(8), .MEM_LATENCY(g + 1)) u_dut (
            .clk(clk), .rst(rst),
            .i_alu_result(alu_r[g]), .i_read_rb_2(rb2[g]), .i_branch_address(baddr[g]),
            .i_inst_mux_br_write_address(wa[g]), .i_zf(zf[g]), .i_branch(br[g]),
            .i_memWrite(mw[g]), .i_memRead(mr[g]), .i_regWrite(rw[g]), .i_memToReg(m2r[g]),
            .o_pc_src(pc_src[g]), .o_branch_target(tgt[g]), .o_stall(stall[g]),
            .o_read_data(o_rd[g]), .o_alu_result(o_alu[g]), .o_write_address(o_wa[g]),
            .o_regWrite(o_rw[g]), .o_memToReg(o_m2r[g]), .o_misaligned(o_mis[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: memory contents with validity, and expected o_read_data
    logic [31:0] ref_mem [3][256];
    logic        ref_valid [3][256];
    logic [31:0] ref_rd [3];
    logic        rd_known [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input int k, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] dst, input logic wr_en,
                          input logic m, input logic b, input logic z, input logic [31:0] ba);
        mr[k] = r; mw[k] = w; alu_r[k] = a; rb2[k] = d; wa[k] = dst;
        rw[k] = wr_en; m2r[k] = m; br[k] = b; zf[k] = z; baddr[k] = ba;
    endtask

    task automatic idle(input int k);
        set_in(k, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // drive one instruction into DUT k (called at a negedge) and check it to completion
    task automatic op(input int k, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [4:0] dst, input logic wr_en,
                      input logic m, input logic b, input logic z, input logic [31:0] ba);
        logic mis, acc;
        int nst;
        int wi;
        mis = (r | w) && (a[1:0] != 2'b00);
        acc = (r | w) && !mis;
        nst = acc ? k : 0;
        wi  = int'(a[9:2]);
        set_in(k, r, w, a, d, dst, wr_en, m, b, z, ba);
        #1;
        check("pc_src", 32'(pc_src[k]), 32'(b & z));
        check("branch_target", tgt[k], ba);
        for (int c = 0; c <= nst; c++) begin
            check($sformatf("stall[%0d] c%0d", k, c), 32'(stall[k]), 32'(c < nst));
            @(posedge clk); #1;
            if (c < nst) begin
                check("bubble regWrite", 32'(o_rw[k]), 0);
                check("bubble memToReg", 32'(o_m2r[k]), 0);
            end else begin
                if (acc && r) begin
                    if (w) begin ref_rd[k] = 0; rd_known[k] = 1; end
                    else begin ref_rd[k] = ref_mem[k][wi]; rd_known[k] = ref_valid[k][wi]; end
                end
                if (acc && w) begin ref_mem[k][wi] = d; ref_valid[k][wi] = 1; end
                check("regWrite", 32'(o_rw[k]), 32'(wr_en & !mis));
                check("memToReg", 32'(o_m2r[k]), 32'(m));
                check("alu_result", o_alu[k], a);
                check("write_address", 32'(o_wa[k]), 32'(dst));
                check("misaligned", 32'(o_mis[k]), 32'(mis));
                if (rd_known[k]) check($sformatf("read_data[%0d]", k), o_rd[k], ref_rd[k]);
            end
            @(negedge clk);
        end
        idle(k);
    endtask

    initial begin
        logic [31:0] a;
        int k, sel;
        for (int i = 0; i < 3; i++) begin
            idle(i);
            ref_rd[i] = 0;
            rd_known[i] = 1;
            for (int j = 0; j < 256; j++) begin ref_valid[i][j] = 0; ref_mem[i][j] = 0; end
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst stall", 32'(stall[i]), 0);
            check("rst read_data", o_rd[i], 0);
            check("rst alu_result", o_alu[i], 0);
            check("rst write_address", 32'(o_wa[i]), 0);
            check("rst regWrite", 32'(o_rw[i]), 0);
            check("rst memToReg", 32'(o_m2r[i]), 0);
            check("rst misaligned", 32'(o_mis[i]), 0);
            check("rst pc_src", 32'(pc_src[i]), 0);
        end
        rst = 1'b0;
        // branch resolves combinationally
        op(0, 0, 0, 32'h55, 0, 5'd3, 1, 0, 1, 1, 32'h0000_4440);
        op(1, 0, 0, 32'h66, 0, 5'd4, 1, 0, 1, 0, 32'h0000_1230);
        // store then load, latency 2
        op(1, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 0, 0, 0);
        op(1, 1, 0, 32'h10, 0, 5'd8, 1, 1, 0, 0, 0);
        // latency 3 load
        op(2, 0, 1, 32'h10, 32'hCAFEF00D, 5'd0, 0, 0, 0, 0, 0);
        op(2, 1, 0, 32'h10, 0, 5'd9, 1, 1, 0, 0, 0);
        // misaligned load and store leave memory untouched
        op(1, 1, 0, 32'h13, 0, 5'd7, 1, 1, 0, 0, 0);
        op(1, 0, 1, 32'h11, 32'h0BAD0BAD, 5'd0, 1, 0, 0, 0, 0);
        op(1, 1, 0, 32'h10, 0, 5'd7, 1, 1, 0, 0, 0);
        // store and load both set
        op(2, 1, 1, 32'h14, 32'h77777777, 5'd5, 1, 1, 0, 0, 0);
        op(2, 1, 0, 32'h14, 0, 5'd5, 1, 1, 0, 0, 0);
        // address aliasing
        for (int i = 0; i < 3; i++) begin
            op(i, 0, 1, 32'h400, 32'h1234, 5'd0, 0, 0, 0, 0, 0);
            op(i, 1, 0, 32'h0, 0, 5'd2, 1, 1, 0, 0, 0);
        end
        // reset during a busy store aborts it
        op(2, 0, 1, 32'h20, 32'h11111111, 5'd0, 0, 0, 0, 0, 0);
        set_in(2, 0, 1, 32'h20, 32'h22222222, 5'd0, 0, 0, 0, 0, 0);
        #1 check("abort stall", 32'(stall[2]), 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        @(posedge clk); #1;
        check("abort stall after rst", 32'(stall[2]), 0);
        check("abort read_data", o_rd[2], 0);
        check("abort regWrite", 32'(o_rw[2]), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin ref_rd[i] = 0; rd_known[i] = 1; end
        op(2, 1, 0, 32'h20, 0, 5'd6, 1, 1, 0, 0, 0);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            k   = $urandom_range(0, 2);
            sel = $urandom_range(0, 5);
            a   = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            op(k, sel == 1 || sel == 2 || sel == 5, sel == 3 || sel == 4 || sel == 5,
               sel == 0 ? $urandom : a, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
